wb_byte_sequencer: RTL and testbench

- Upstream companion to the 32-to-8-bit Wishbone data resizer.
- Accepts classic 32-bit Wishbone accesses with any byte-select pattern. Issues one single-lane (one-hot sel) access per set sel bit, serially, toward the resizer/8-bit slave.
- Gathers read bytes into a 32-bit word and terminates the master cycle once, after all lanes complete or on the first error/retry.

---
 rtl/wb_byte_sequencer.sv | 157 +++++++++++++++
 tb/tb_wb_byte_sequencer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_byte_sequencer.sv
// Splits a 32-bit classic Wishbone access into one single-lane access per selected byte,
// highest lane first, gathering read bytes and terminating the master once.
module wb_byte_sequencer #(
    parameter int aw = 32,
    parameter int dw = 32
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_ni,
    input  logic [aw-1:0] wbm_adr_i,
    input  logic [dw-1:0] wbm_dat_i,
    input  logic [3:0]    wbm_sel_i,
    input  logic          wbm_we_i,
    input  logic          wbm_cyc_i,
    input  logic          wbm_stb_i,
    input  logic [2:0]    wbm_cti_i,
    input  logic [1:0]    wbm_bte_i,
    output logic [dw-1:0] wbm_sdt_o,
    output logic          wbm_ack_o,
    output logic          wbm_err_o,
    output logic          wbm_rty_o,
    output logic [aw-1:0] wbs_adr_o,
    output logic [dw-1:0] wbs_dat_o,
    output logic [3:0]    wbs_sel_o,
    output logic          wbs_we_o,
    output logic          wbs_cyc_o,
    output logic          wbs_stb_o,
    output logic [2:0]    wbs_cti_o,
    output logic [1:0]    wbs_bte_o,
    input  logic [dw-1:0] wbs_sdt_i,
    input  logic          wbs_ack_i,
    input  logic          wbs_err_i,
    input  logic          wbs_rty_i
);
    typedef enum logic [1:0] {IDLE, ACCESS, GAP, DONE} state_t;
    typedef enum logic [1:0] {TERM_ACK, TERM_ERR, TERM_RTY} term_t;

    state_t          state_q, state_d;
    term_t           term_q, term_d;
    logic [aw-3:0]   adr_q, adr_d;
    logic [dw-1:0]   dat_q, dat_d;
    logic            we_q, we_d;
    logic [3:0]      pend_q, pend_d;
    logic [dw-1:0]   rdata_q, rdata_d;
    logic [1:0]      lane;
    logic [3:0]      lane_oh;
    logic            unused_inputs;

    // Burst signalling is ignored: every access is treated as classic.
    assign unused_inputs = ^{wbm_cti_i, wbm_bte_i, wbm_adr_i[1:0]};

    always_comb begin
        lane = 2'd0;
        if (pend_q[3])      lane = 2'd3;
        else if (pend_q[2]) lane = 2'd2;
        else if (pend_q[1]) lane = 2'd1;
        lane_oh = 4'b0001 << lane;
    end

    always_comb begin
        state_d   = state_q;
        term_d    = term_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        we_d      = we_q;
        pend_d    = pend_q;
        rdata_d   = rdata_q;
        wbm_ack_o = 1'b0;
        wbm_err_o = 1'b0;
        wbm_rty_o = 1'b0;
        wbs_cyc_o = 1'b0;
        wbs_stb_o = 1'b0;
        wbs_sel_o = 4'b0000;
        wbs_adr_o = '0;
        case (state_q)
            IDLE: begin
                if (wbm_cyc_i && wbm_stb_i) begin
                    adr_d   = wbm_adr_i[aw-1:2];
                    dat_d   = wbm_dat_i;
                    we_d    = wbm_we_i;
                    pend_d  = wbm_sel_i;
                    rdata_d = '0;
                    term_d  = TERM_ACK;
                    state_d = (wbm_sel_i == 4'b0000) ? DONE : ACCESS;
                end
            end
            ACCESS: begin
                wbs_adr_o = {adr_q, 2'd3 - lane};
                if (!wbm_cyc_i) begin
                    pend_d  = 4'b0000;
                    state_d = IDLE;
                end else begin
                    wbs_cyc_o = 1'b1;
                    wbs_stb_o = 1'b1;
                    wbs_sel_o = lane_oh;
                    if (wbs_err_i) begin
                        term_d  = TERM_ERR;
                        pend_d  = 4'b0000;
                        state_d = DONE;
                    end else if (wbs_rty_i) begin
                        term_d  = TERM_RTY;
                        pend_d  = 4'b0000;
                        state_d = DONE;
                    end else if (wbs_ack_i) begin
                        if (!we_q)
                            rdata_d[{lane, 3'b000} +: 8] = wbs_sdt_i[{lane, 3'b000} +: 8];
                        pend_d  = pend_q & ~lane_oh;
                        state_d = (pend_d == 4'b0000) ? DONE : GAP;
                    end
                end
            end
            GAP: begin
                // Strobe stays low for a cycle so a registered slave ack is not seen twice.
                wbs_adr_o = {adr_q, 2'd3 - lane};
                if (!wbm_cyc_i) begin
                    pend_d  = 4'b0000;
                    state_d = IDLE;
                end else begin
                    wbs_cyc_o = 1'b1;
                    state_d   = ACCESS;
                end
            end
            DONE: begin
                wbm_ack_o = (term_q == TERM_ACK);
                wbm_err_o = (term_q == TERM_ERR);
                wbm_rty_o = (term_q == TERM_RTY);
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            state_q <= IDLE;
            term_q  <= TERM_ACK;
            adr_q   <= '0;
            dat_q   <= '0;
            we_q    <= 1'b0;
            pend_q  <= 4'b0000;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            term_q  <= term_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            we_q    <= we_d;
            pend_q  <= pend_d;
            rdata_q <= rdata_d;
        end
    end

    assign wbm_sdt_o = rdata_q;
    assign wbs_dat_o = dat_q;
    assign wbs_we_o  = we_q;
    assign wbs_cti_o = 3'b000;
    assign wbs_bte_o = 2'b00;
endmodule

// File: tb/tb_wb_byte_sequencer.sv
// Cycle-accurate timeline model of wb_byte_sequencer built per transaction from the
// selected lanes, slave wait states and terminations; directed cases plus random traffic.
module tb_wb_byte_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] wbm_adr_i = '0, wbm_dat_i = '0;
    logic [3:0]  wbm_sel_i = '0;
    logic        wbm_we_i = 1'b0, wbm_cyc_i = 1'b0, wbm_stb_i = 1'b0;
    logic [2:0]  wbm_cti_i = '0;
    logic [1:0]  wbm_bte_i = '0;
    logic [31:0] wbm_sdt_o;
    logic        wbm_ack_o, wbm_err_o, wbm_rty_o;
    logic [31:0] wbs_adr_o, wbs_dat_o;
    logic [3:0]  wbs_sel_o;
    logic        wbs_we_o, wbs_cyc_o, wbs_stb_o;
    logic [2:0]  wbs_cti_o;
    logic [1:0]  wbs_bte_o;
    logic [31:0] wbs_sdt_i = '0;
    logic        wbs_ack_i = 1'b0, wbs_err_i = 1'b0, wbs_rty_i = 1'b0;

    always #5 clk = ~clk;

    wb_byte_sequencer #(.aw(32), .dw(32)) dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n),
        .wbm_adr_i(wbm_adr_i), .wbm_dat_i(wbm_dat_i), .wbm_sel_i(wbm_sel_i),
        .wbm_we_i(wbm_we_i), .wbm_cyc_i(wbm_cyc_i), .wbm_stb_i(wbm_stb_i),
        .wbm_cti_i(wbm_cti_i), .wbm_bte_i(wbm_bte_i),
        .wbm_sdt_o(wbm_sdt_o), .wbm_ack_o(wbm_ack_o), .wbm_err_o(wbm_err_o),
        .wbm_rty_o(wbm_rty_o),
        .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o), .wbs_sel_o(wbs_sel_o),
        .wbs_we_o(wbs_we_o), .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o),
        .wbs_cti_o(wbs_cti_o), .wbs_bte_o(wbs_bte_o),
        .wbs_sdt_i(wbs_sdt_i), .wbs_ack_i(wbs_ack_i), .wbs_err_i(wbs_err_i),
        .wbs_rty_i(wbs_rty_i)
    );

    int vectors = 0;
    int miscompares = 0;

    // Per-access slave behaviour, indexed in issue order: wait states, termination
    // (1 ack, 2 err, 3 rty, 4 ack+rty, 5 ack+err) and the read data word returned.
    int          t_w[4];
    int          t_term[4];
    logic [31:0] t_sdat[4];

    // Expected timeline, indexed by cycle relative to request presentation.
    logic        e_cyc[64];
    logic        e_stb[64];
    logic [3:0]  e_sel[64];
    logic [31:0] e_adr[64];
    int          e_term[64];
    int          e_idx[64];
    int          e_mterm[64];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_slave_default();
        for (int i = 0; i < 4; i++) begin
            t_w[i] = 0;
            t_term[i] = 1;
            t_sdat[i] = $urandom;
        end
    endtask

    // Entered and left at posedge+1; the call's first cycle is cycle 0.
    task automatic run_txn(input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, input logic we, input int abort_idx,
                           output int done_cyc, output logic [31:0] done_sdt);
        int lanes[4];
        int n, c, end_c, fin, abort_c, mt, last;
        logic [31:0] exp_word;
        logic [2:0]  exp_m;
        logic        mcyc;
        for (int k = 0; k < 64; k++) begin
            e_cyc[k] = 0; e_stb[k] = 0; e_sel[k] = 0; e_adr[k] = 0;
            e_term[k] = 0; e_idx[k] = 0; e_mterm[k] = 0;
        end
        n = 0;
        for (int l = 3; l >= 0; l--)
            if (sel[l]) begin lanes[n] = l; n++; end
        exp_word = 0; c = 1; fin = -1; abort_c = -1; mt = 1;
        if (n == 0) fin = 1;
        for (int i = 0; i < n; i++) begin
            if (i == abort_idx) begin abort_c = c; break; end
            for (int k = 0; k <= t_w[i]; k++) begin
                e_cyc[c+k] = 1; e_stb[c+k] = 1; e_idx[c+k] = i;
                e_sel[c+k] = 4'b0001 << lanes[i];
                e_adr[c+k] = {adr[31:2], 2'(3 - lanes[i])};
            end
            end_c = c + t_w[i];
            e_term[end_c] = t_term[i];
            if (t_term[i] == 1) begin
                if (!we) exp_word[lanes[i]*8 +: 8] = t_sdat[i][lanes[i]*8 +: 8];
                if (i == n - 1) fin = end_c + 1;
                else begin e_cyc[end_c+1] = 1; c = end_c + 2; end
            end else begin
                fin = end_c + 1;
                mt = (t_term[i] == 2 || t_term[i] == 5) ? 2 : 3;
                break;
            end
        end
        if (fin >= 0) e_mterm[fin] = mt;
        last = ((fin >= 0) ? fin : abort_c) + 3;
        done_cyc = -1; done_sdt = 0;
        wbm_adr_i = adr; wbm_dat_i = dat; wbm_sel_i = sel; wbm_we_i = we;
        for (int cy = 0; cy <= last; cy++) begin
            mcyc = (abort_c < 0 || cy < abort_c) && (fin < 0 || cy <= fin);
            wbm_cyc_i = mcyc; wbm_stb_i = mcyc;
            wbs_ack_i = (e_term[cy] == 1 || e_term[cy] == 4 || e_term[cy] == 5);
            wbs_err_i = (e_term[cy] == 2 || e_term[cy] == 5);
            wbs_rty_i = (e_term[cy] == 3 || e_term[cy] == 4);
            wbs_sdt_i = e_stb[cy] ? t_sdat[e_idx[cy]] : $urandom;
            @(negedge clk);
            chk("wbs_cyc", 32'(wbs_cyc_o), 32'(e_cyc[cy]));
            chk("wbs_stb", 32'(wbs_stb_o), 32'(e_stb[cy]));
            exp_m = (e_mterm[cy] == 1) ? 3'b100 : (e_mterm[cy] == 2) ? 3'b010 :
                    (e_mterm[cy] == 3) ? 3'b001 : 3'b000;
            chk("wbm_ack_err_rty", 32'({wbm_ack_o, wbm_err_o, wbm_rty_o}), 32'(exp_m));
            if (e_stb[cy]) begin
                chk("wbs_sel", 32'(wbs_sel_o), 32'(e_sel[cy]));
                chk("wbs_adr", wbs_adr_o, e_adr[cy]);
                chk("wbs_we", 32'(wbs_we_o), 32'(we));
                chk("wbs_dat", wbs_dat_o, dat);
            end
            if (e_mterm[cy] != 0) chk("wbm_sdt", wbm_sdt_o, exp_word);
            if ({wbm_ack_o, wbm_err_o, wbm_rty_o} != 3'b000 && done_cyc < 0) begin
                done_cyc = cy;
                done_sdt = wbm_sdt_o;
            end
            @(posedge clk); #1;
        end
        wbm_cyc_i = 0; wbm_stb_i = 0;
        wbs_ack_i = 0; wbs_err_i = 0; wbs_rty_i = 0;
        $display("txn adr=%08h sel=%b we=%0d abort=%0d done_cyc=%0d sdt=%08h",
                 adr, sel, we, abort_idx, done_cyc, done_sdt);
    endtask

    initial begin
        int          dc;
        logic [31:0] ds;
        logic [3:0]  rsel;
        int          r, ab;

        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_wbs_cyc", 32'(wbs_cyc_o), 0);
        chk("rst_wbs_stb", 32'(wbs_stb_o), 0);
        chk("rst_wbs_sel", 32'(wbs_sel_o), 0);
        chk("rst_wbm_term", 32'({wbm_ack_o, wbm_err_o, wbm_rty_o}), 0);
        chk("rst_wbm_sdt", wbm_sdt_o, 0);
        @(posedge clk); #1;
        rst_n = 1;

        // Four-lane write, zero-wait slave: ack lands in cycle 8.
        set_slave_default();
        run_txn(32'h100, 32'hAABBCCDD, 4'b1111, 1'b1, -1, dc, ds);
        chk("lit_write4_done", dc, 8);

        // Read of lanes 2 and 0 gathers only the selected bytes.
        set_slave_default();
        t_sdat[0] = 32'hEE11EEEE;
        t_sdat[1] = 32'hEEEEEE22;
        run_txn(32'h200, 32'h0, 4'b0101, 1'b0, -1, dc, ds);
        chk("lit_read2_sdt", ds, 32'h00110022);
        chk("lit_read2_done", dc, 4);

        set_slave_default();
        run_txn(32'h300, 32'h12345678, 4'b0000, 1'b0, -1, dc, ds);
        chk("lit_sel0_done", dc, 1);

        set_slave_default();
        t_term[1] = 2;
        run_txn(32'h400, 32'h55667788, 4'b1111, 1'b1, -1, dc, ds);
        chk("lit_err_done", dc, 4);

        set_slave_default();
        t_term[1] = 4;
        run_txn(32'h500, 32'h0, 4'b1110, 1'b0, -1, dc, ds);
        chk("lit_rty_done", dc, 4);

        set_slave_default();
        t_w[0] = 2; t_w[1] = 2;
        run_txn(32'h600, 32'h0, 4'b0011, 1'b0, -1, dc, ds);
        chk("lit_wait2_done", dc, 8);

        set_slave_default();
        run_txn(32'h700, 32'hCAFEF00D, 4'b1111, 1'b1, 1, dc, ds);
        chk("lit_abort_done", dc, 32'hFFFFFFFF);

        // Reset while an access is stalled waiting for the slave.
        wbm_adr_i = 32'h800; wbm_dat_i = 32'h0BADBEEF; wbm_sel_i = 4'b1111;
        wbm_we_i = 1; wbm_cyc_i = 1; wbm_stb_i = 1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 0;
        @(posedge clk); #1;
        rst_n = 1; wbm_cyc_i = 0; wbm_stb_i = 0;
        @(negedge clk);
        chk("midrst_wbs_cyc", 32'(wbs_cyc_o), 0);
        chk("midrst_wbs_stb", 32'(wbs_stb_o), 0);
        chk("midrst_wbs_sel", 32'(wbs_sel_o), 0);
        chk("midrst_wbs_adr", wbs_adr_o, 0);
        chk("midrst_wbs_dat", wbs_dat_o, 0);
        chk("midrst_wbs_we", 32'(wbs_we_o), 0);
        chk("midrst_wbm_term", 32'({wbm_ack_o, wbm_err_o, wbm_rty_o}), 0);
        @(posedge clk); #1;
        set_slave_default();
        run_txn(32'h900, 32'h0, 4'b1001, 1'b0, -1, dc, ds);
        chk("lit_after_rst_done", dc, 4);

        for (int t = 0; t < 40; t++) begin
            rsel = 4'($urandom);
            for (int i = 0; i < 4; i++) begin
                t_w[i] = $urandom_range(0, 3);
                r = $urandom_range(0, 15);
                t_term[i] = (r < 11) ? 1 : (r == 11) ? 2 : (r == 12) ? 3 : (r == 13) ? 4 : 5;
                t_sdat[i] = $urandom;
            end
            ab = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 3) : -1;
            run_txn($urandom, $urandom, rsel, 1'($urandom), ab, dc, ds);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
